// File: rtl/i2s_mic_emulator_pkg.sv
// Shared defaults and helpers for the I2S microphone emulator.
package i2s_mic_pkg;

    localparam int unsigned W_SAMPLE_DEF    = 24;
    localparam int unsigned W_SLOT_DEF      = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Width of a counter that must reach w_slot-1.
    function automatic int unsigned bit_cnt_width(input int unsigned slot);
        return (slot > 1) ? $clog2(slot) : 1;
    endfunction

endpackage

// File: rtl/i2s_mic_emulator_edge_sync.sv
// N-stage synchronizer for an asynchronous level, with single-clk
// rise/fall pulses derived from the synchronized level.
module i2s_edge_sync
    import i2s_mic_pkg::*;
#(
    parameter int unsigned stages = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [stages-1:0] sync_q;
    logic              last_q;

    // Shift the async input through the synchronizer chain; keep the
    // previous synced level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[stages-2:0], async_i};
            last_q <= sync_q[stages-1];
        end
    end

    assign level_o = sync_q[stages-1];
    assign rise_o  = sync_q[stages-1] & ~last_q;
    assign fall_o  = ~sync_q[stages-1] & last_q;

endmodule

// File: rtl/i2s_mic_emulator.sv
// I2S slave transmitter emulating an INMP441-style microphone: follows
// external sck/ws and shifts out w_sample-bit words MSB first in its own
// channel slot, fed by a one-deep valid/ready holding register.
module i2s_mic_emulator
    import i2s_mic_pkg::*;
#(
    parameter int unsigned w_sample    = W_SAMPLE_DEF,
    parameter int unsigned w_slot      = W_SLOT_DEF,
    parameter int unsigned sync_stages = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lr,
    input  logic                sck,
    input  logic                ws,
    output logic                sd,
    output logic                sd_oe,
    input  logic [w_sample-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                underrun
);

    localparam int unsigned   CW      = bit_cnt_width(w_slot);
    localparam logic [CW-1:0] CNT_MAX = CW'(w_slot - 1);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic ws_lvl, ws_rise_unused, ws_fall_unused;

    i2s_edge_sync #(.stages(sync_stages)) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (sck),
        .level_o (sck_lvl_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    i2s_edge_sync #(.stages(sync_stages)) u_ws_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ws),
        .level_o (ws_lvl),
        .rise_o  (ws_rise_unused),
        .fall_o  (ws_fall_unused)
    );

    logic                ws_vld_q, ws_vld_d;
    logic                ws_prev_q, ws_prev_d;
    logic                own_slot_q, own_slot_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [w_sample-1:0] shift_q, shift_d;
    logic [w_sample-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                rdy_q, rdy_d;
    logic                underrun_q, underrun_d;
    logic                sd_q, sd_d;
    logic                sd_oe_q, sd_oe_d;

    logic slot_start, own_start, accept;

    // Next-state logic: slot detection, word load, bit shifting, handshake.
    always_comb begin
        ws_vld_d    = ws_vld_q;
        ws_prev_d   = ws_prev_q;
        own_slot_d  = own_slot_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        sd_d        = sd_q;
        sd_oe_d     = sd_oe_q;

        // ws is only meaningful at a sck rise; the first rise after reset
        // just seeds the history so a stale level cannot look like an edge.
        slot_start = sck_rise & ws_vld_q & (ws_lvl != ws_prev_q);
        own_start  = slot_start & (ws_lvl == lr);
        accept     = sample_valid & rdy_q;

        if (sck_rise) begin
            ws_prev_d = ws_lvl;
            ws_vld_d  = 1'b1;
        end

        if (slot_start) begin
            bit_cnt_d  = '0;
            own_slot_d = (ws_lvl == lr);
        end

        // Load consumes the holding register before any accept on this clk;
        // accept needs rdy_q, which is low whenever the register was full.
        if (own_start) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        if (sck_fall) begin
            if (own_slot_q && (32'(bit_cnt_q) < w_sample)) begin
                sd_d    = shift_q[w_sample-1];
                sd_oe_d = 1'b1;
                shift_d = {shift_q[w_sample-2:0], 1'b0};
            end else begin
                sd_d    = 1'b0;
                sd_oe_d = 1'b0;
            end
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end

        rdy_d = ~hold_full_d;
    end

    // State register with synchronous reset; ready stays low during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_vld_q    <= 1'b0;
            ws_prev_q   <= 1'b0;
            own_slot_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rdy_q       <= 1'b0;
            underrun_q  <= 1'b0;
            sd_q        <= 1'b0;
            sd_oe_q     <= 1'b0;
        end else begin
            ws_vld_q    <= ws_vld_d;
            ws_prev_q   <= ws_prev_d;
            own_slot_q  <= own_slot_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rdy_q       <= rdy_d;
            underrun_q  <= underrun_d;
            sd_q        <= sd_d;
            sd_oe_q     <= sd_oe_d;
        end
    end

    assign sd           = sd_q;
    assign sd_oe        = sd_oe_q;
    assign sample_ready = rdy_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_mic_emulator.sv
// Directed bench: acts as I2S master (sck/ws) and sample source, captures
// the serial word per slot and compares against hand-computed values.
module tb_i2s_mic_emulator;

    localparam int unsigned H = 6;  // sck half-period in clk cycles

    logic        clk;
    logic        rst;
    logic        lr;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        sd_oe;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned urun_cnt = 0;

    i2s_mic_emulator #(
        .w_sample    (24),
        .w_slot      (32),
        .sync_stages (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lr           (lr),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .sd_oe        (sd_oe),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count underrun pulses away from the active edge.
    always @(negedge clk) if (underrun) urun_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One ws slot of nsck sck cycles. ws changes on the first fall; the bit
    // sampled on rise k (k>=1) is data bit k-1 of this slot.
    task automatic do_slot(input logic ws_v, input int unsigned nsck,
                           output logic [23:0] word, output int unsigned oe_hi,
                           output int unsigned idle_bad);
        word = '0;
        oe_hi = 0;
        idle_bad = 0;
        for (int unsigned k = 0; k < nsck; k++) begin
            @(negedge clk);
            sck = 1'b0;
            if (k == 0) ws = ws_v;
            repeat (H - 1) @(negedge clk);
            @(negedge clk);
            if (k >= 1 && k <= 24) begin
                word = {word[22:0], sd};
                if (sd_oe) oe_hi++;
            end else if (k > 24) begin
                if (sd || sd_oe) idle_bad++;
            end
            sck = 1'b1;
            repeat (H - 1) @(negedge clk);
        end
    endtask

    task automatic push(input logic [23:0] d);
        int unsigned n = 0;
        @(negedge clk);
        sample_in = d;
        sample_valid = 1'b1;
        while (!sample_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(sample_ready), 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
        check("ready_drop", 32'(sample_ready), 32'd0);
    endtask

    logic [23:0] w;
    int unsigned oh, ib, base;

    initial begin
        sample_in = '0;
        sample_valid = 1'b0;
        lr = 1'b1;
        ws = 1'b0;
        sck = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sd", 32'(sd), 32'd0);
        check("rst_oe", 32'(sd_oe), 32'd0);
        check("rst_urun", 32'(underrun), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_post_rst", 32'(sample_ready), 32'd1);

        // Extremes, lr=1: transmit while ws=1.
        base = urun_cnt;
        push(24'h800000);
        do_slot(1'b0, 32, w, oh, ib);
        check("other_oe_0", oh, 0);
        do_slot(1'b1, 32, w, oh, ib);
        check("word_800000", 32'(w), 32'h800000);
        check("own_oe_24", oh, 24);
        check("idle_24_31", ib, 0);
        check("ready_after_load", 32'(sample_ready), 32'd1);
        push(24'h7FFFFF);
        do_slot(1'b0, 32, w, oh, ib);
        check("other_oe_1", oh, 0);
        check("other_sd_0", 32'(w), 32'h0);
        do_slot(1'b1, 32, w, oh, ib);
        check("word_7fffff", 32'(w), 32'h7FFFFF);
        check("idle_24_31b", ib, 0);
        check("no_urun_1", urun_cnt - base, 0);

        // Underrun: nothing supplied.
        base = urun_cnt;
        do_slot(1'b0, 32, w, oh, ib);
        do_slot(1'b1, 32, w, oh, ib);
        check("urun_word", 32'(w), 32'h0);
        check("urun_once", urun_cnt - base, 1);
        check("urun_ready", 32'(sample_ready), 32'd1);
        do_slot(1'b0, 32, w, oh, ib);
        do_slot(1'b1, 32, w, oh, ib);
        check("urun_twice", urun_cnt - base, 2);

        // Valid held with changing data while full.
        base = urun_cnt;
        push(24'h123456);
        sample_valid = 1'b1;
        sample_in = 24'h0F0F0F;
        fork
            do_slot(1'b0, 32, w, oh, ib);
            begin
                repeat (40) begin
                    @(negedge clk);
                    sample_in = sample_in + 24'h111111;
                end
            end
        join
        check("full_ready_0", 32'(sample_ready), 32'd0);
        sample_in = 24'hA5F00F;
        do_slot(1'b1, 32, w, oh, ib);
        check("word_A", 32'(w), 32'h123456);
        check("ready_B_taken", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;
        sample_in = 24'hDEAD00;
        do_slot(1'b0, 32, w, oh, ib);
        do_slot(1'b1, 32, w, oh, ib);
        check("word_B", 32'(w), 32'hA5F00F);
        check("ready_after_B", 32'(sample_ready), 32'd1);
        check("no_urun_hs", urun_cnt - base, 0);

        // Short own slot: 16 sck, word truncated.
        base = urun_cnt;
        push(24'hC3A5F0);
        do_slot(1'b0, 32, w, oh, ib);
        do_slot(1'b1, 16, w, oh, ib);
        check("short_bits", 32'(w[14:0]), 32'h61D2);
        check("short_oe", oh, 15);
        push(24'h3C5A96);
        do_slot(1'b0, 32, w, oh, ib);
        check("after_short_other", oh, 0);
        do_slot(1'b1, 32, w, oh, ib);
        check("word_after_short", 32'(w), 32'h3C5A96);
        check("no_urun_short", urun_cnt - base, 0);

        // Reset during bit 10 of own slot.
        push(24'h6B2D4F);
        do_slot(1'b0, 32, w, oh, ib);
        do_slot(1'b1, 11, w, oh, ib);
        check("pre_rst_bits", 32'(w[9:0]), 32'h1AC);
        check("oe_before_rst", 32'(sd_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_sd", 32'(sd), 32'd0);
        check("rst_mid_oe", 32'(sd_oe), 32'd0);
        check("rst_mid_ready", 32'(sample_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_rst2", 32'(sample_ready), 32'd1);
        base = urun_cnt;
        push(24'h2468AC);
        do_slot(1'b1, 21, w, oh, ib);
        check("quiet_rest_slot", oh, 0);
        do_slot(1'b0, 32, w, oh, ib);
        check("quiet_other", oh, 0);
        do_slot(1'b1, 32, w, oh, ib);
        check("word_after_rst", 32'(w), 32'h2468AC);
        check("no_urun_rst", urun_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
